// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Converts arrow-key and WASD make codes into a 2-bit direction with a one-cycle strobe.
// Converts Enter (0x5A, with or without E0) into a one-cycle acknowledge strobe.
// Receive-only: the block never drives the PS/2 lines.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous, active-high reset
//   PS2_Clk    keyboard clock (asynchronous)
//   PS2_Data   keyboard data (asynchronous)
//   In_Dirn    last decoded direction: 00 up, 01 down, 10 left, 11 right
//   SCEN_dir   one-cycle strobe per decoded direction make code
//   Ack_Pulse  one-cycle strobe per Enter make code
//   Frame_Err  one-cycle strobe on a parity, stop-bit or timeout error
//   Rx_Byte    last correctly received byte
module ps2_dir_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [1:0] In_Dirn,
  output logic       SCEN_dir,
  output logic       Ack_Pulse,
  output logic       Frame_Err,
  output logic [7:0] Rx_Byte
);

  localparam int unsigned FcntW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  // Synchronizers reset to the idle-high bus level.
  logic [1:0] clk_sync_q, dat_sync_q;

  logic             filt_q, filt_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             fall;

  logic [1:0]      state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            e0_q, e0_d, f0_q, f0_d;

  logic [1:0] dirn_q, dirn_d;
  logic       scen_q, scen_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  logic       frame_ok;
  logic [7:0] rx_data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_Clk};
      dat_sync_q <= {dat_sync_q[0], PS2_Data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FcntW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // shift_q holds {stop, parity, data[7:0]} once ten bits have been shifted in LSB first.
  assign rx_data  = shift_q[7:0];
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    e0_d      = e0_q;
    f0_d      = f0_q;
    dirn_d    = dirn_q;
    scen_d    = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rx_byte_d = rx_byte_q;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall && !dat_sync_q[1]) begin
          state_d   = StShift;
          bit_cnt_d = '0;
        end
      end

      StShift: begin
        if (fall) begin
          tmo_d     = '0;
          shift_d   = {dat_sync_q[1], shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StCheck;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          // Partial byte is dropped along with any pending prefix.
          state_d = StIdle;
          err_d   = 1'b1;
          e0_d    = 1'b0;
          f0_d    = 1'b0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StCheck: begin
        state_d = StIdle;
        tmo_d   = '0;
        if (!frame_ok) begin
          err_d = 1'b1;
          e0_d  = 1'b0;
          f0_d  = 1'b0;
        end else begin
          rx_byte_d = rx_data;
          if (rx_data == 8'hE0) begin
            e0_d = 1'b1;
          end else if (rx_data == 8'hF0) begin
            f0_d = 1'b1;
          end else begin
            e0_d = 1'b0;
            f0_d = 1'b0;
            // Break codes (F0 prefix) produce no output.
            if (!f0_q) begin
              if (e0_q) begin
                case (rx_data)
                  8'h75:   begin dirn_d = 2'b00; scen_d = 1'b1; end
                  8'h72:   begin dirn_d = 2'b01; scen_d = 1'b1; end
                  8'h6B:   begin dirn_d = 2'b10; scen_d = 1'b1; end
                  8'h74:   begin dirn_d = 2'b11; scen_d = 1'b1; end
                  8'h5A:   ack_d = 1'b1;
                  default: ;
                endcase
              end else begin
                case (rx_data)
                  8'h1D:   begin dirn_d = 2'b00; scen_d = 1'b1; end
                  8'h1B:   begin dirn_d = 2'b01; scen_d = 1'b1; end
                  8'h1C:   begin dirn_d = 2'b10; scen_d = 1'b1; end
                  8'h23:   begin dirn_d = 2'b11; scen_d = 1'b1; end
                  8'h5A:   ack_d = 1'b1;
                  default: ;
                endcase
              end
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      e0_q      <= 1'b0;
      f0_q      <= 1'b0;
      dirn_q    <= 2'b00;
      scen_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      e0_q      <= e0_d;
      f0_q      <= f0_d;
      dirn_q    <= dirn_d;
      scen_q    <= scen_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign In_Dirn   = dirn_q;
  assign SCEN_dir  = scen_q;
  assign Ack_Pulse = ack_q;
  assign Frame_Err = err_q;
  assign Rx_Byte   = rx_byte_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder: stimulus pushes expected events, a monitor pops them.
module tb_ps2_dir_decoder;

  localparam int unsigned FilterLen  = 8;
  localparam int unsigned TimeoutCyc = 2000;
  localparam int          Half       = 40;

  localparam int KDir = 0;
  localparam int KAck = 1;
  localparam int KErr = 2;

  typedef struct {
    int         kind;
    logic [1:0] dirn;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [1:0] in_dirn;
  logic       scen_dir;
  logic       ack_pulse;
  logic       frame_err;
  logic [7:0] rx_byte;

  int  checks;
  int  failures;
  ev_t exp_q[$];
  ev_t mon_e;
  int  act_kind;

  ps2_dir_decoder #(
    .FILTER_LEN (FilterLen),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .PS2_Clk  (ps2_clk),
    .PS2_Data (ps2_dat),
    .In_Dirn  (in_dirn),
    .SCEN_dir (scen_dir),
    .Ack_Pulse(ack_pulse),
    .Frame_Err(frame_err),
    .Rx_Byte  (rx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (scen_dir || ack_pulse || frame_err)) begin
      checks++;
      if ($countones({scen_dir, ack_pulse, frame_err}) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive got scen=%0b ack=%0b err=%0b expected one", scen_dir,
                 ack_pulse, frame_err);
      end
      act_kind = scen_dir ? KDir : (ack_pulse ? KAck : KErr);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got kind=%0d expected none", act_kind);
      end else begin
        mon_e = exp_q.pop_front();
        if (act_kind != mon_e.kind) begin
          failures++;
          $display("FAIL event_kind got %0d expected %0d", act_kind, mon_e.kind);
        end else if (mon_e.kind == KDir) begin
          checks++;
          if (in_dirn !== mon_e.dirn) begin
            failures++;
            $display("FAIL in_dirn got %b expected %b", in_dirn, mon_e.dirn);
          end
        end
      end
    end
  end

  task automatic push_ev(input int kind, input logic [1:0] dirn);
    ev_t e;
    e.kind = kind;
    e.dirn = dirn;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the first nedges bits of a frame; optional short glitches in both clock phases.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nedges,
                            input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_dat = bits[i];
      if (glitch) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(Half - 13);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b0;
      if (glitch) begin
        wait_cyc(15);
        ps2_clk = 1'b1;
        wait_cyc(3);
        ps2_clk = 1'b0;
        wait_cyc(Half - 18);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(Half);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_dirn"}, {6'd0, in_dirn}, 8'h00);
    check_val({tag, "_scen"}, {7'd0, scen_dir}, 8'h00);
    check_val({tag, "_ack"}, {7'd0, ack_pulse}, 8'h00);
    check_val({tag, "_err"}, {7'd0, frame_err}, 8'h00);
    check_val({tag, "_rx_byte"}, rx_byte, 8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(5);

    // Up arrow.
    push_ev(KDir, 2'b00);
    send_byte(8'hE0);
    send_byte(8'h75);
    @(negedge clk);
    check_val("rx_after_up", rx_byte, 8'h75);

    // Break of right arrow gives nothing; then A -> left.
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    @(negedge clk);
    check_val("dirn_after_break", {6'd0, in_dirn}, 8'h00);
    push_ev(KDir, 2'b10);
    send_byte(8'h1C);
    @(negedge clk);
    check_val("rx_after_a", rx_byte, 8'h1C);

    // Bad parity on D, then a good D.
    push_ev(KErr, 2'b00);
    send_frame(8'h23, 1'b1, 11, 1'b0);
    @(negedge clk);
    check_val("rx_after_bad_parity", rx_byte, 8'h1C);
    push_ev(KDir, 2'b11);
    send_byte(8'h23);
    @(negedge clk);
    check_val("rx_after_d", rx_byte, 8'h23);

    // Stalled frame times out, then Enter.
    push_ev(KErr, 2'b00);
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    wait_cyc(TimeoutCyc + 200);
    @(negedge clk);
    check_val("rx_after_timeout", rx_byte, 8'h23);
    push_ev(KAck, 2'b00);
    send_byte(8'h5A);
    @(negedge clk);
    check_val("rx_after_enter", rx_byte, 8'h5A);
    check_val("dirn_after_enter", {6'd0, in_dirn}, 8'h03);

    // Down arrow with clock glitches.
    push_ev(KDir, 2'b01);
    send_frame(8'hE0, 1'b0, 11, 1'b1);
    send_frame(8'h72, 1'b0, 11, 1'b1);
    @(negedge clk);
    check_val("rx_after_glitch", rx_byte, 8'h72);

    // Reset in the middle of a frame.
    send_frame(8'h1C, 1'b0, 7, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    wait_cyc(Half);
    push_ev(KDir, 2'b10);
    send_byte(8'hE0);
    send_byte(8'h6B);
    @(negedge clk);
    check_val("rx_after_left", rx_byte, 8'h6B);
    check_val("dirn_after_left", {6'd0, in_dirn}, 8'h02);

    wait_cyc(50);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
